clock_set_controller: RTL and testbench
=======================================

// Module: clock_set_controller
// PURPOSE
//  Front end that drives the set/up/down inputs of the clock's BCD digit counters from three raw push-buttons.
//  Synchronises and debounces MODE/UP/DOWN, then steps a field-select FSM: RUN -> SET field 0 .. N-1 -> RUN.
//  Issues one-clock active-low up/down pulses to the selected field only; set_ena freezes all fields while setting.
// PARAMETERS
//  NUM_FIELDS       3         number of settable fields (0 = most significant, e.g. hours)
//  DEBOUNCE_CYCLES  500000    consecutive stable samples required to accept a new button level
//  REPEAT_DELAY     25000000  held-button cycles before first auto-repeat pulse (AUTO_REPEAT_EN only)
//  REPEAT_PERIOD    5000000   cycles between subsequent auto-repeat pulses (AUTO_REPEAT_EN only)
// PORTS
//  clk          in   1           system clock, all logic on posedge
//  rst          in   1           synchronous reset, active high
//  btn_mode_n   in   1           raw MODE button, active low, asynchronous
//  btn_up_n     in   1           raw UP button, active low, asynchronous
//  btn_down_n   in   1           raw DOWN button, active low, asynchronous
//  set_ena      out  1           1 in any SET state (all counters hold), 0 in RUN (counters free-run)
//  up_n         out  NUM_FIELDS  per-field increment strobe, active low, 1 clk wide
//  down_n       out  NUM_FIELDS  per-field decrement strobe, active low, 1 clk wide
//  field        out  $clog2(NUM_FIELDS)  index of selected field; 0 in RUN
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=RUN, set_ena=0, up_n/down_n all 1, field=0, debounced levels=1 (released),
//    all debounce/repeat counters=0. Reset mid-press drops the press; no pulse until release and re-press.
//  - Sync: each button through 2 flops. Debounce: per-button counter; sync level != debounced level -> count,
//    equal -> clear; count reaching DEBOUNCE_CYCLES-1 with mismatch -> debounced level updates, counter clears.
//  - Press event = debounced level 1->0, one clk. Release events generate nothing.
//  - FSM states RUN, SET(i) i=0..NUM_FIELDS-1. MODE event: RUN->SET(0); SET(i)->SET(i+1); SET(N-1)->RUN.
//    set_ena and field registered, change the clk after the MODE event.
//  - In SET(i): UP event -> up_n[i]=0 for exactly the next clk; DOWN event -> down_n[i]=0 likewise.
//    Other bits of up_n/down_n stay 1. In RUN, UP/DOWN events ignored; all strobes 1.
//  - Simultaneous events in one clk: MODE wins (state advances, UP/DOWN dropped);
//    UP and DOWN together -> no pulse. up_n and down_n never both low.
//  - Latency: button stable low from cycle t -> strobe low at cycle t+DEBOUNCE_CYCLES+3.
//  - Strobe low on last SET cycle still completes its single clk even as set_ena falls; no strobe in RUN.
//  - Counter widths: debounce ceil(log2(DEBOUNCE_CYCLES)), repeat ceil(log2(max(REPEAT_DELAY,REPEAT_PERIOD))); no wrap.
// CONFIGURATION
//  AUTO_REPEAT_EN defined: while UP (or DOWN) stays debounced-pressed in SET(i), after the initial pulse
//    a further pulse fires REPEAT_DELAY cycles after the press event, then every REPEAT_PERIOD cycles.
//    Release, MODE event, state change, or the other button pressing cancels and clears the repeat counter.
//  AUTO_REPEAT_EN undefined: exactly one strobe per press event; repeat counters and params unused, not synthesised.
// TESTING  (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, NUM_FIELDS=3)
//  - Reset: rst=1 two clks, buttons released -> set_ena=0, field=0, up_n=3'b111, down_n=3'b111.
//  - Bounce: btn_up_n toggles every 2 clks for 20 clks in SET(0) -> no strobe; then held low -> up_n=3'b110 for
//    1 clk at 7 clks after the low level became stable.
//  - FSM: 4 clean MODE presses -> field 0,1,2 with set_ena=1, then RUN with set_ena=0, field=0.
//  - Routing: in SET(1) press DOWN -> down_n=3'b101 one clk; in RUN press UP -> no strobe.
//  - Priority: MODE and UP debounced in same clk in SET(0) -> field=1, up_n stays 3'b111; UP+DOWN together -> none.
//  - Repeat (AUTO_REPEAT_EN): hold UP 40 clks past event in SET(2) -> pulses at +0,+20,+25,+30,+35,+40; without
//    macro -> single pulse at +0.

Source files
------------

// File: rtl/clock_set_controller.sv
// clock_set_controller: debounced MODE/UP/DOWN front end stepping a field-select FSM and strobing up_n/down_n.
// Optional AUTO_REPEAT_EN adds held-button auto-repeat pulses.
module clock_set_controller #(
  parameter int NUM_FIELDS      = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_mode_n,
  input  logic                  btn_up_n,
  input  logic                  btn_down_n,
  output logic                  set_ena,
  output logic [NUM_FIELDS-1:0] up_n,
  output logic [NUM_FIELDS-1:0] down_n,
  output logic [(NUM_FIELDS > 1 ? $clog2(NUM_FIELDS) : 1)-1:0] field
);
  localparam int FW = NUM_FIELDS > 1 ? $clog2(NUM_FIELDS) : 1;
  localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  typedef enum logic {RUN, SET} state_t;
  state_t st;
  logic [2:0] raw, s1, s2, arm, deb, deb_q, ev;
  logic [DW-1:0] cnt [3];
  logic pu, pd;
  assign raw = {btn_down_n, btn_up_n, btn_mode_n};
  assign ev  = deb_q & ~deb;
  // arm stays low until a released level is seen, so a press held through reset is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= '0;
      s2    <= '0;
      arm   <= '0;
      deb   <= '1;
      deb_q <= '1;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      arm   <= arm | s2;
      deb_q <= deb;
      for (int i = 0; i < 3; i++)
        if (!arm[i] || s2[i] == deb[i]) cnt[i] <= '0;
        else if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
    end
  end
`ifdef AUTO_REPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = RMAX > 1 ? $clog2(RMAX) : 1;
  logic rep_on, rep_up, rep_rpt, held, hit;
  logic [RW-1:0] rcnt;
  assign held = rep_up ? ~deb[1] : ~deb[2];
  assign hit  = rep_on && held && rcnt == (rep_rpt ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1));
  assign pu   = ev[1] ? ~ev[2] : hit & rep_up & ~ev[2];
  assign pd   = ev[2] ? ~ev[1] : hit & ~rep_up & ~ev[1];
  // rep_rpt selects the first (delay) or subsequent (period) interval
  always_ff @(posedge clk) begin
    if (rst || ev[0] || st == RUN || (ev[1] && ev[2])) begin
      rep_on  <= 1'b0;
      rep_up  <= 1'b0;
      rep_rpt <= 1'b0;
      rcnt    <= '0;
    end else if (ev[1] || ev[2]) begin
      rep_on  <= 1'b1;
      rep_up  <= ev[1];
      rep_rpt <= 1'b0;
      rcnt    <= '0;
    end else if (!rep_on || !held) begin
      rep_on  <= 1'b0;
      rep_rpt <= 1'b0;
      rcnt    <= '0;
    end else if (hit) begin
      rep_rpt <= 1'b1;
      rcnt    <= '0;
    end else rcnt <= rcnt + 1'b1;
  end
`else
  assign pu = ev[1] & ~ev[2];
  assign pd = ev[2] & ~ev[1];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= RUN;
      set_ena <= 1'b0;
      field   <= '0;
      up_n    <= '1;
      down_n  <= '1;
    end else begin
      up_n   <= '1;
      down_n <= '1;
      if (ev[0]) begin
        if (st == RUN) begin
          st      <= SET;
          set_ena <= 1'b1;
          field   <= '0;
        end else if (field == FW'(NUM_FIELDS - 1)) begin
          st      <= RUN;
          set_ena <= 1'b0;
          field   <= '0;
        end else field <= field + 1'b1;
      end else if (st == SET) begin
        up_n[field]   <= ~pu;
        down_n[field] <= ~pd;
      end
    end
  end
endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller: directed checks of debounce, field FSM, strobe routing, priority and repeat.
module tb_clock_set_controller;
  logic clk = 0, rst = 1, bm = 1, bu = 1, bd = 1;
  logic set_ena;
  logic [2:0] up_n, down_n;
  logic [1:0] field;
  int cyc = 0, tests = 0, fails = 0, k = 0;
  int lc[$];
  logic [5:0] lv[$];
  int exp_off[$];

  clock_set_controller #(.NUM_FIELDS(3), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)) dut (
    .clk(clk), .rst(rst), .btn_mode_n(bm), .btn_up_n(bu), .btn_down_n(bd),
    .set_ena(set_ena), .up_n(up_n), .down_n(down_n), .field(field)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (!rst && (up_n !== 3'b111 || down_n !== 3'b111)) begin
      lc.push_back(cyc);
      lv.push_back({up_n, down_n});
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [2:0] m);
    {bd, bu, bm} = ~m;
    step(10);
    {bd, bu, bm} = 3'b111;
    step(10);
  endtask

  task automatic clear_log();
    lc.delete();
    lv.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
`ifdef AUTO_REPEAT_EN
    exp_off = '{0, 20, 25, 30, 35, 40};
`else
    exp_off = '{0};
`endif
    step(2);
    check("rst_set_ena", set_ena, 0);
    check("rst_field", field, 0);
    check("rst_up_n", up_n, 3'b111);
    check("rst_down_n", down_n, 3'b111);
    rst = 0;
    step(3);
    for (int i = 0; i < 4; i++) begin
      press(3'b001);
      check("fsm_field", field, i < 3 ? i : 0);
      check("fsm_set_ena", set_ena, i < 3);
    end
    check("fsm_no_strobe", lc.size(), 0);
    press(3'b001);
    clear_log();
    for (int i = 0; i < 10; i++) begin
      bu = i[0];
      step(2);
    end
    bu = 0;
    k = cyc;
    step(12);
    bu = 1;
    step(12);
    check("bounce_count", lc.size(), 1);
    check("bounce_cycle", lc.size() > 0 ? lc[0] : -1, k + 7);
    check("bounce_value", lv.size() > 0 ? lv[0] : 6'h0, 6'b110111);
    press(3'b001);
    clear_log();
    press(3'b100);
    check("route_down_count", lc.size(), 1);
    check("route_down_value", lv.size() > 0 ? lv[0] : 6'h0, 6'b111101);
    press(3'b001);
    press(3'b001);
    check("route_run_set_ena", set_ena, 0);
    clear_log();
    press(3'b010);
    check("route_run_no_strobe", lc.size(), 0);
    press(3'b001);
    clear_log();
    press(3'b011);
    check("prio_mode_field", field, 1);
    check("prio_mode_no_strobe", lc.size(), 0);
    press(3'b110);
    check("prio_updown_no_strobe", lc.size(), 0);
    check("prio_updown_field", field, 1);
    press(3'b001);
    check("rep_field", field, 2);
    clear_log();
    bu = 0;
    k = cyc;
    step(43);
    bu = 1;
    step(15);
    check("rep_count", lc.size(), exp_off.size());
    for (int i = 0; i < exp_off.size(); i++) begin
      check("rep_cycle", i < lc.size() ? lc[i] : -1, k + 7 + exp_off[i]);
      check("rep_value", i < lv.size() ? lv[i] : 6'h0, 6'b011111);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
